ccff_chain_loader: RTL and testbench

- Upstream configuration stage for `fpga_top`.
- Accepts configuration beats, one bit per chain, over a valid/ready stream.
- Drives the beats onto the parallel `ccff_head[0:NUM_CHAINS-1]` scan chains with a per-bit shift enable, counting exactly CHAIN_LEN shifts.
- After loading, waits a programmable settle time, then releases `global_resetn` to the fabric and flags `cfg_done`. It also checks `ccff_tail` for residual data during the load.

---
 rtl/ccff_loader_pkg.sv | 20 ++
 rtl/ccff_release_timer.sv | 39 +++
 rtl/ccff_chain_loader.sv | 118 +++++++++++
 tb/tb_ccff_chain_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration chain loader.
// Holds the loader FSM encoding and counter sizing.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEF_NUM_CHAINS = 10;
  localparam int DEF_CHAIN_LEN  = 1024;

  // Bits needed to hold 0..len; never narrower than one bit
  function automatic int cnt_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/ccff_release_timer.sv
// Settle-time down-counter between the last chain shift and fabric release.
// Loaded on SETTLE entry; expire is high once the count reaches zero.
module ccff_release_timer
  import ccff_loader_pkg::*;
#(
  parameter int RELEASE_DLY = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = cnt_width(RELEASE_DLY);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = TW'(RELEASE_DLY);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams configuration beats onto parallel scan chains, then
// releases the fabric reset after a programmable settle time.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int NUM_CHAINS  = DEF_NUM_CHAINS,
  parameter int CHAIN_LEN   = DEF_CHAIN_LEN,
  parameter int CNT_W       = 11,
  parameter int RELEASE_DLY = 16
) (
  input  logic                  prog_clock,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [NUM_CHAINS-1:0] s_data,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  ccff_shift_en,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  tail_err,
  output logic [CNT_W-1:0]      beat_count,
  output logic                  global_resetn
);

  state_e state_q;
  state_e state_d;

  logic [NUM_CHAINS-1:0] head_q;
  logic [NUM_CHAINS-1:0] head_d;
  logic                  shift_q;
  logic                  shift_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  err_q;
  logic                  err_d;
  logic                  done_q;
  logic                  done_d;

  logic accept;
  logic last_beat;
  logic expire;

  assign s_ready   = (state_q == LOAD);
  assign accept    = s_valid & s_ready;
  assign last_beat = accept && (cnt_q == CNT_W'(CHAIN_LEN - 1));

  ccff_release_timer #(
    .RELEASE_DLY(RELEASE_DLY)
  ) u_timer (
    .clk_i   (prog_clock),
    .rst_i   (prog_reset),
    .load_i  (last_beat),
    .en_i    (state_q == SETTLE),
    .expire_o(expire)
  );

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    shift_d = accept;
    cnt_d   = cnt_q;
    // Any residual chain data seen while shifting is latched until restart
    err_d   = err_q | (shift_q & (|ccff_tail));
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          head_d = s_data;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (expire) begin
          state_d = DONE;
        end
      end
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge prog_clock or posedge prog_reset) begin
    if (prog_reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      shift_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_q;
  assign busy          = (state_q == LOAD) || (state_q == SETTLE);
  assign cfg_done      = done_q;
  assign global_resetn = done_q;
  assign tail_err      = err_q;
  assign beat_count    = cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: stimulus queues expected
// chain words, a negedge monitor checks every strobe and hold cycle.
module tb_ccff_chain_loader;

  localparam int NC = 10;
  localparam int CL = 4;
  localparam int CW = 3;
  localparam int RD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [NC-1:0] s_data = '0;
  logic [NC-1:0] tail = '0;

  logic          s_ready;
  logic [NC-1:0] head;
  logic          shift_en;
  logic          busy;
  logic          cfg_done;
  logic          tail_err;
  logic [CW-1:0] beat_count;
  logic          gres;

  int tests = 0;
  int fails = 0;
  int strobes = 0;

  logic [NC-1:0] sb[$];
  logic [NC-1:0] last_exp = '0;

  ccff_chain_loader #(
    .NUM_CHAINS (NC),
    .CHAIN_LEN  (CL),
    .CNT_W      (CW),
    .RELEASE_DLY(RD)
  ) dut (
    .prog_clock   (clk),
    .prog_reset   (rst),
    .start        (start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .ccff_head    (head),
    .ccff_shift_en(shift_en),
    .ccff_tail    (tail),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .tail_err     (tail_err),
    .beat_count   (beat_count),
    .global_resetn(gres)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      last_exp = '0;
    end else if (shift_en) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got head %0h expected no strobe", head);
      end else begin
        last_exp = sb.pop_front();
        chk("strobe_head", head, last_exp);
        strobes++;
      end
    end else begin
      chk("head_hold", head, last_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [NC-1:0] b0, input logic [NC-1:0] b1,
                      input logic [NC-1:0] b2, input logic [NC-1:0] b3,
                      input int first, input int last,
                      input logic [15:0] pat, input int tidx);
    logic [NC-1:0] bt[4];
    int k;
    int p;
    bit acc;
    bt = '{b0, b1, b2, b3};
    k = first;
    p = 0;
    while (k <= last && p < 40) begin
      s_valid = (p < 16) ? pat[p] : 1'b1;
      s_data = bt[k];
      acc = s_valid && s_ready;
      if (acc) sb.push_back(bt[k]);
      tick();
      tail = (acc && k == tidx) ? 10'h004 : '0;
      if (acc) k++;
      p++;
    end
    s_valid = 1'b0;
    if (k <= last) chk("send_timeout", k, last + 1);
  endtask

  task automatic settle_chk();
    chk("settle_ready", s_ready, 1'b0);
    chk("settle_busy", busy, 1'b1);
    chk("settle_count", beat_count, CL);
    chk("settle_last_strobe", shift_en, 1'b1);
  endtask

  task automatic wait_done(input int exp_n);
    int n;
    n = 0;
    while (!gres && n < 12) begin
      tick();
      n++;
    end
    chk("release_cycles", n, exp_n);
    chk("done_flag", cfg_done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_count", beat_count, CL);
  endtask

  task automatic restart_chk();
    chk("restart_gres", gres, 1'b0);
    chk("restart_done", cfg_done, 1'b0);
    chk("restart_err", tail_err, 1'b0);
    chk("restart_count", beat_count, 0);
    chk("restart_ready", s_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_head", head, 0);
    chk("rst_shift", shift_en, 1'b0);
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", tail_err, 1'b0);
    chk("rst_count", beat_count, 0);
    chk("rst_gres", gres, 1'b0);
    rst = 1'b0;
    repeat (4) tick();
    chk("idle_ready", s_ready, 1'b0);
    chk("idle_strobes", strobes, 0);

    // back-to-back load
    do_start();
    chk("load_ready", s_ready, 1'b1);
    chk("load_count0", beat_count, 0);
    strobes = 0;
    send(10'h001, 10'h3FF, 10'h155, 10'h2AA, 0, 3, 16'hFFFF, -1);
    settle_chk();
    wait_done(RD + 1);
    chk("b2b_err", tail_err, 1'b0);
    chk("b2b_strobes", strobes, CL);

    // valid toggling 1,0,0,1,1,0,1
    do_start();
    restart_chk();
    strobes = 0;
    send(10'h0F0, 10'h30F, 10'h0AA, 10'h155, 0, 3, 16'h0059, -1);
    settle_chk();
    wait_done(RD + 1);
    chk("gap_strobes", strobes, CL);

    // residual tail data on the 2nd strobe
    do_start();
    restart_chk();
    send(10'h011, 10'h022, 10'h044, 10'h088, 0, 3, 16'hFFFF, 1);
    settle_chk();
    wait_done(RD + 1);
    chk("tail_err_set", tail_err, 1'b1);
    repeat (2) tick();
    chk("tail_err_sticky", tail_err, 1'b1);
    chk("tail_done_hold", cfg_done, 1'b1);

    // start mid-load is ignored, extra beat refused
    do_start();
    restart_chk();
    strobes = 0;
    send(10'h101, 10'h202, 10'h303, 10'h004, 0, 1, 16'hFFFF, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_start_count", beat_count, 2);
    chk("mid_start_ready", s_ready, 1'b1);
    send(10'h101, 10'h202, 10'h303, 10'h004, 2, 3, 16'hFFFF, -1);
    settle_chk();
    s_valid = 1'b1;
    s_data = 10'h3C3;
    repeat (3) tick();
    chk("extra_ready", s_ready, 1'b0);
    chk("extra_count", beat_count, CL);
    s_valid = 1'b0;
    wait_done(1);
    chk("mid_strobes", strobes, CL);

    // asynchronous abort after the 3rd beat
    do_start();
    send(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 0, 2, 16'hFFFF, -1);
    rst = 1'b1;
    #1;
    chk("abort_head", head, 0);
    chk("abort_shift", shift_en, 1'b0);
    chk("abort_ready", s_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_count", beat_count, 0);
    chk("abort_gres", gres, 1'b0);
    chk("abort_done", cfg_done, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post_abort_ready", s_ready, 1'b0);
    chk("post_abort_busy", busy, 1'b0);
    chk("post_abort_gres", gres, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
